// File: rtl/led_pkg.sv
// led_pkg: shared constants and message ROM for the LED scroller.
// The message nibbles double as glyph indices for the LED decoder.
package led_pkg;

   localparam int MSG_LEN = 16;
   localparam int POS_W   = $clog2(MSG_LEN);

   // Default message: nibble value equals its index, repeating every 16.
   function automatic logic [3:0] msg_nibble(input int unsigned idx);
      return 4'(idx % 16);
   endfunction

endpackage

// File: rtl/led_message_scroller_if.sv
// led_message_scroller_if: button/mode inputs and the scrolled
// window outputs between the scroller and its neighbours.
interface led_message_scroller_if
   import led_pkg::*;
#(
   parameter int IF_POS_W = POS_W
);

   logic                btn;
   logic                mode;
   logic [3:0]          char3;
   logic [3:0]          char2;
   logic [3:0]          char1;
   logic [3:0]          char0;
   logic [IF_POS_W-1:0] pos;
   logic                step_pulse;

   modport master (
      output btn, mode,
      input  char3, char2, char1, char0, pos, step_pulse
   );

   modport slave (
      input  btn, mode,
      output char3, char2, char1, char0, pos, step_pulse
   );

endinterface

// File: rtl/led_message_scroller_btn_debouncer.sv
// btn_debouncer: 2-flop synchronizer, stable-level debouncer and
// a registered one-cycle pulse on each accepted press.
module btn_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press
);

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Synchronizer, debounced level, mismatch counter and press flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   // Count cycles of disagreement; accept the new level once it has held.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      press_d = level_d & ~level_q;
   end

   assign press = press_q;

endmodule

// File: rtl/led_message_scroller.sv
// led_message_scroller: four-nibble window over a fixed message,
// stepped by a scroll timer (auto) or a debounced button (manual).
module led_message_scroller
   import led_pkg::*;
#(
   parameter int MSG_LEN         = led_pkg::MSG_LEN,
   parameter int SCROLL_DIV      = 50000000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input logic                   clk,
   input logic                   reset,
   led_message_scroller_if.slave bus
);

   localparam int            PW   = $clog2(MSG_LEN);
   localparam int            TW   = $clog2(SCROLL_DIV);
   localparam logic [TW-1:0] TMAX = TW'(SCROLL_DIV - 1);

   logic [TW-1:0] tmr_q, tmr_d;
   logic [PW-1:0] pos_q, pos_d;
   logic [3:0]    win_q [4];
   logic [3:0]    win_d [4];
   logic [PW-1:0] idx;
   logic          step_q, step_d;
   logic          press;
   logic          tick;
   logic          adv;

   btn_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb (
      .clk   (clk),
      .reset (reset),
      .btn   (bus.btn),
      .press (press)
   );

   // Scroll timer: free-runs in auto mode, parked at zero in manual.
   always_comb begin
      tmr_d = '0;
      tick  = 1'b0;
      if (!bus.mode) begin
         tick  = (tmr_q == TMAX);
         tmr_d = tick ? '0 : tmr_q + TW'(1);
      end
   end

   // Advance: new start index and all four nibbles move together.
   always_comb begin
      adv    = bus.mode ? press : tick;
      pos_d  = pos_q;
      win_d  = win_q;
      idx    = '0;
      step_d = adv;
      if (adv) begin
         pos_d = pos_q + PW'(1);
         for (int k = 0; k < 4; k++) begin
            idx      = pos_d + PW'(k);
            win_d[k] = msg_nibble(32'(idx));
         end
      end
   end

   // Timer, position, window and step strobe registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmr_q  <= '0;
         pos_q  <= '0;
         step_q <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            win_q[k] <= msg_nibble(k);
         end
      end else begin
         tmr_q  <= tmr_d;
         pos_q  <= pos_d;
         step_q <= step_d;
         win_q  <= win_d;
      end
   end

   assign bus.char3      = win_q[0];
   assign bus.char2      = win_q[1];
   assign bus.char1      = win_q[2];
   assign bus.char0      = win_q[3];
   assign bus.pos        = pos_q;
   assign bus.step_pulse = step_q;

endmodule
